// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
// Build option: define MEM_ARBITER_RR_EN for round-robin tie-break; default is fixed priority to requester 0.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic                  grant_q;
    logic                  busy_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  win_sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef MEM_ARBITER_RR_EN
    logic                  prio_q;  // requester favoured on the next tie
`endif

    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        win_sel = (req0 && req1) ? prio_q : !req0;
`else
        win_sel = !req0;
`endif
        sel_we    = win_sel ? we1    : we0;
        sel_addr  = win_sel ? addr1  : addr0;
        sel_wdata = win_sel ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            grant_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= win_sel;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        // strobe is registered here so it is high for exactly the ISSUE cycle
                        wr_en_q <= sel_we;
                        rd_en_q <= !sel_we;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
`ifdef MEM_ARBITER_RR_EN
                        prio_q  <= !win_sel;
`endif
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            if (grant_q) begin
                                rdata1_q <= mem_data_out;
                            end else begin
                                rdata0_q <= mem_data_out;
                            end
                        end
                        if (grant_q) begin
                            ack1_q <= 1'b1;
                        end else begin
                            ack0_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign mem_write_en = wr_en_q;
    assign mem_read_en  = rd_en_q;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign busy         = busy_q;
    assign grant        = grant_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_write_en && mem_read_en));
    a_strobe_in_issue: assert property (@(posedge clk) disable iff (rst)
        (mem_write_en || mem_read_en) |-> (state_q == ISSUE));
    a_ack_excl: assert property (@(posedge clk) disable iff (rst)
        !(ack0 && ack1));

endmodule
